lut_neuron_bank: RTL and testbench

- Runtime-programmable, pipelined bank of NUM_NEURONS LogicNets-style truth-table neurons.
- Each neuron maps a FANIN-bit input slice to an OUT_BITS-bit output through its own 2^FANIN-entry table.
- Tables are loaded over a config port rather than frozen in a case statement, so a layer can be retrained without resynthesis.
- Sits between layer registers in the quantum-net datapath, with valid/ready handshakes on both sides.

---
 rtl/lut_neuron_bank.sv | 95 +++++++++
 tb/tb_lut_neuron_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_bank.sv
// Runtime-programmable bank of truth-table neurons with a two-stage valid/ready pipeline.
// Tables are written over the config port and are deliberately left out of reset.
module lut_neuron_bank #(
  parameter int NUM_NEURONS = 4,
  parameter int FANIN       = 6,
  parameter int OUT_BITS    = 1,
  parameter int NIDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*FANIN-1:0]    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic [NIDX_W-1:0]               cfg_neuron,
  input  logic [FANIN-1:0]                cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_ready,
  output logic                            cfg_err
);

  localparam int DEPTH  = 2 ** FANIN;
  localparam int TIDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic [OUT_BITS-1:0]             tables [NUM_NEURONS][DEPTH];
  logic                            s1_valid;
  logic                            s2_valid;
  logic [NUM_NEURONS*FANIN-1:0]    s1_data;
  logic [NUM_NEURONS*OUT_BITS-1:0] s2_data;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
  logic                            stall;
  logic                            in_fire;
  logic                            idx_ok;
  logic                            cfg_commit;
  logic [TIDX_W-1:0]               wr_idx;

  // Stall looks at S2 only, so an empty S1 can still fill behind a stalled output.
  assign stall      = s2_valid && !out_ready;
  assign in_ready   = !cfg_we && (!s1_valid || !stall);
  assign in_fire    = in_valid && in_ready;

  assign cfg_ready  = !s1_valid && !s2_valid && !in_valid;
  assign idx_ok     = int'(cfg_neuron) < NUM_NEURONS;
  assign cfg_commit = cfg_we && cfg_ready && idx_ok;
  assign wr_idx     = cfg_neuron[TIDX_W-1:0];

  assign out_valid  = s2_valid;
  assign out_data   = s2_data;

  always_comb begin
    lookup = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      lookup[n*OUT_BITS +: OUT_BITS] = tables[n][s1_data[n*FANIN +: FANIN]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
      end else if (!stall) begin
        s1_valid <= 1'b0;
      end
      if (!stall) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= lookup;
        end
      end
      cfg_err <= cfg_we && !cfg_commit;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_data <= in_data;
    end
  end

  // Single write port, one combinational read port per neuron (distributed RAM).
  always_ff @(posedge clk) begin
    if (cfg_commit) begin
      tables[wr_idx][cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_lut_neuron_bank.sv
// Directed bench for lut_neuron_bank: shadow truth tables feed a scoreboard queue of
// expected output vectors, compared whenever the bank hands a vector downstream.
module tb_lut_neuron_bank;

  localparam int NN = 4;
  localparam int FI = 6;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NN*FI-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NN-1:0] out_data;
  logic          cfg_we;
  logic [2:0]    cfg_neuron;
  logic [FI-1:0] cfg_addr;
  logic [0:0]    cfg_data;
  logic          cfg_ready;
  logic          cfg_err;

  int          asserts;
  int          fails;
  int          out_count;
  int          idx;
  int          outs_before;
  bit          acc;
  logic        model_tab [NN][64];
  logic [NN-1:0] sb [$];
  logic [NN*FI-1:0] bp [4];

  lut_neuron_bank #(
    .NUM_NEURONS(NN),
    .FANIN(FI),
    .OUT_BITS(1),
    .NIDX_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .cfg_we(cfg_we),
    .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NN*FI-1:0] vec(input int s3, input int s2, input int s1, input int s0);
    return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  function automatic logic [NN-1:0] modelOut(input logic [NN*FI-1:0] d);
    logic [NN-1:0] r;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      r[n] = model_tab[n][d[n*FI +: FI]];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [NN*FI-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  // Sample handshakes just after the inputs settle, then advance to the next falling edge.
  task automatic cycle();
    #1;
    acc = in_valid && in_ready;
    if (acc) sb.push_back(modelOut(in_data));
    if (out_valid && out_ready) begin
      out_count++;
      if (sb.size() == 0) checkOutput("spurious_out", 32'(out_valid), 32'd0);
      else checkOutput("out_data", 32'(out_data), 32'(sb.pop_front()));
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int c = 0; c < 12 && sb.size() > 0; c++) cycle();
    checkOutput("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic cfgWrite(input int n, input int a, input logic d, input bit commit);
    cfg_we     = 1'b1;
    cfg_neuron = 3'(n);
    cfg_addr   = 6'(a);
    cfg_data   = d;
    cycle();
    cfg_we = 1'b0;
    if (commit) model_tab[n][a] = d;
  endtask

  initial begin
    asserts = 0; fails = 0; out_count = 0; idx = 0;
    rst_n = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    applyStimulus(1'b0, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] loading reference tables");
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < 64; a++)
        cfgWrite(n, a, (n == 0 && (a == 12 || a == 15)) ? 1'b1 : 1'b0, 1'b1);

    $display("[TB] streaming reference function");
    applyStimulus(1'b1, vec(0, 0, 0, 12));
    cycle();
    applyStimulus(1'b1, vec(0, 0, 0, 28));
    checkOutput("lat_cycle1", 32'(out_valid), 32'd0);
    cycle();
    applyStimulus(1'b1, vec(0, 0, 0, 15));
    checkOutput("lat_cycle2", 32'(out_valid), 32'd1);
    checkOutput("ref_first", 32'(out_data), 32'd1);
    cycle();
    applyStimulus(1'b0, '0);
    checkOutput("stream_gap1", 32'(out_valid), 32'd1);
    cycle();
    checkOutput("stream_gap2", 32'(out_valid), 32'd1);
    cycle();
    checkOutput("stream_done", 32'(out_valid), 32'd0);
    checkOutput("stream_sb", sb.size(), 32'd0);

    $display("[TB] per-neuron isolation");
    for (int k = 0; k < NN; k++) cfgWrite(k, 5, k[0], 1'b1);
    checkOutput("iso_cfg_err", 32'(cfg_err), 32'd0);
    applyStimulus(1'b1, vec(5, 5, 5, 5));
    cycle();
    applyStimulus(1'b0, '0);
    cycle();
    checkOutput("iso_pattern", 32'(out_data), 32'b1010);
    drain();

    $display("[TB] backpressure");
    bp[0] = vec(0, 0, 0, 12);
    bp[1] = vec(0, 0, 5, 0);
    bp[2] = vec(5, 0, 0, 0);
    bp[3] = vec(5, 0, 5, 15);
    out_ready = 1'b0; idx = 0;
    applyStimulus(1'b1, bp[0]);
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (acc) begin
        idx++;
        if (idx < 4) in_data = bp[idx];
      end
      if (c >= 1) begin
        checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_hold_data", 32'(out_data), 32'b0001);
      end
    end
    checkOutput("bp_accepted", idx, 32'd2);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    outs_before = out_count;
    for (int c = 0; c < 20 && (out_count - outs_before) < 4; c++) begin
      cycle();
      if (acc) begin
        idx++;
        if (idx < 4) in_data = bp[idx];
        else in_valid = 1'b0;
      end
    end
    checkOutput("bp_all_out", out_count - outs_before, 32'd4);
    checkOutput("bp_sb_empty", sb.size(), 32'd0);

    $display("[TB] config conflict");
    out_ready = 1'b0;
    applyStimulus(1'b1, vec(0, 0, 5, 0));
    cycle();
    applyStimulus(1'b0, '0);
    cycle();
    cfg_we = 1'b1; cfg_neuron = 3'd1; cfg_addr = 6'd5; cfg_data = 1'b0;
    checkOutput("conf_cfg_ready", 32'(cfg_ready), 32'd0);
    cycle();
    cfg_we = 1'b0;
    checkOutput("conf_err_pulse", 32'(cfg_err), 32'd1);
    cycle();
    checkOutput("conf_err_clear", 32'(cfg_err), 32'd0);
    out_ready = 1'b1;
    drain();
    applyStimulus(1'b1, vec(0, 0, 5, 0));
    cycle();
    applyStimulus(1'b0, '0);
    drain();

    $display("[TB] out-of-range neuron index");
    cfg_we = 1'b1; cfg_neuron = 3'd4; cfg_addr = 6'd5; cfg_data = 1'b1;
    checkOutput("oor_cfg_ready", 32'(cfg_ready), 32'd1);
    cycle();
    cfg_we = 1'b0;
    checkOutput("oor_err_pulse", 32'(cfg_err), 32'd1);
    cycle();
    checkOutput("oor_err_clear", 32'(cfg_err), 32'd0);

    $display("[TB] config priority over data");
    cfg_we = 1'b1; cfg_neuron = 3'd2; cfg_addr = 6'd5; cfg_data = 1'b1;
    applyStimulus(1'b1, vec(0, 0, 0, 12));
    #1;
    checkOutput("prio_in_ready", 32'(in_ready), 32'd0);
    checkOutput("prio_cfg_ready", 32'(cfg_ready), 32'd0);
    cycle();
    checkOutput("prio_err_pulse", 32'(cfg_err), 32'd1);
    applyStimulus(1'b0, '0);
    #1;
    checkOutput("prio_cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cycle();
    cfg_we = 1'b0;
    model_tab[2][5] = 1'b1;
    checkOutput("prio_commit_err", 32'(cfg_err), 32'd0);
    applyStimulus(1'b1, vec(5, 5, 5, 5));
    cycle();
    applyStimulus(1'b0, '0);
    drain();

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(1'b1, vec(5, 5, 5, 5));
    cycle();
    applyStimulus(1'b1, vec(0, 0, 0, 12));
    cycle();
    applyStimulus(1'b0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    outs_before = out_count;
    repeat (3) cycle();
    checkOutput("mid_rst_no_output", out_count - outs_before, 32'd0);
    applyStimulus(1'b1, vec(5, 5, 5, 5));
    cycle();
    applyStimulus(1'b0, '0);
    cycle();
    checkOutput("post_rst_result", 32'(out_data), 32'b1110);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
